// File: rtl/ip_arb_pkg.sv
// rtl/ip_arb_pkg.sv - shared types and constants for the multi-slave burst arbiter
package ip_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        XFER       = 2'd1,
        WAIT_CMPLT = 2'd2
    } arb_state_t;

    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Index width for n channels; never narrower than one bit.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ip_multi_arbiter_rr_picker.sv
// rtl/ip_multi_arbiter_rr_picker.sv - combinational round-robin picker starting at rr_ptr
module rr_picker
    import ip_arb_pkg::*;
#(
    parameter  int NUM_SLV = 4,
    localparam int SRC_W   = src_w(NUM_SLV)
) (
    input  logic [NUM_SLV-1:0] elig,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [SRC_W-1:0]   grant,
    output logic               any
);

    logic [2*NUM_SLV-1:0] elig2;
    logic [NUM_SLV-1:0]   rot;
    int                   sum;

    // Rotate the request vector so that bit 0 is the channel at rr_ptr.
    assign elig2 = {elig, elig};
    assign rot   = NUM_SLV'(elig2 >> rr_ptr);

    // Lowest set bit of the rotated vector wins; map it back to a channel index.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        sum   = 0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = int'(rr_ptr) + i;
                any = 1'b1;
            end
        end
        if (sum >= NUM_SLV) begin
            sum = sum - NUM_SLV;
        end
        grant = SRC_W'(sum);
    end

endmodule

// File: rtl/ip_multi_arbiter.sv
// rtl/ip_multi_arbiter.sv - N-slave round-robin burst arbiter feeding the processing pipeline
module ip_multi_arbiter
    import ip_arb_pkg::*;
#(
    parameter  int NUM_SLV = 4,
    parameter  int DW      = 32,
    parameter  int CNT_W   = 8,
    localparam int SRC_W   = src_w(NUM_SLV)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SLV-1:0][1:0]       slv_mode,
    input  logic [NUM_SLV-1:0]            slv_data_valid,
    input  logic [NUM_SLV-1:0][CNT_W-1:0] slv_proc_valid,
    input  logic [NUM_SLV-1:0][DW-1:0]    slv_data,
    output logic [NUM_SLV-1:0]            slv_ready,
    input  logic                          fifo_full,
    input  logic                          proc_cmplt,
    output logic [1:0]                    slvx_mode,
    output logic [CNT_W-1:0]              slvx_proc_val,
    output logic                          slvx_data_valid,
    output logic [DW-1:0]                 slvx_data,
    output logic [SRC_W-1:0]              data_source,
    output logic                          mstr0_cmplt
);

    arb_state_t         state;
    logic [SRC_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [NUM_SLV-1:0] elig;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;
    logic               accept;

    // A slave may only compete with a live request, a non-empty burst and a usable mode.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            elig[i] = slv_data_valid[i] && (slv_proc_valid[i] != '0) && (slv_mode[i] != MODE_RSVD);
        end
    end

    rr_picker #(
        .NUM_SLV (NUM_SLV)
    ) u_picker (
        .elig   (elig),
        .rr_ptr (rr_ptr),
        .grant  (pick_idx),
        .any    (pick_any)
    );

    // Ready goes only to the granted slave, and drops in the same cycle the FIFO fills.
    always_comb begin
        slv_ready = '0;
        if (state == XFER && !fifo_full) begin
            slv_ready[data_source] = 1'b1;
        end
    end

    assign accept = (state == XFER) && !fifo_full && slv_data_valid[data_source];

    // Grant FSM with beat counter and registered outputs toward the processing module.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            beat_cnt        <= '0;
            data_source     <= '0;
            slvx_mode       <= '0;
            slvx_proc_val   <= '0;
            slvx_data_valid <= 1'b0;
            slvx_data       <= '0;
            mstr0_cmplt     <= 1'b0;
        end else begin
            slvx_data_valid <= 1'b0;
            mstr0_cmplt     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        data_source   <= pick_idx;
                        slvx_mode     <= slv_mode[pick_idx];
                        slvx_proc_val <= slv_proc_valid[pick_idx];
                        beat_cnt      <= slv_proc_valid[pick_idx];
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        slvx_data_valid <= 1'b1;
                        slvx_data       <= slv_data[data_source];
                        beat_cnt        <= beat_cnt - CNT_W'(1);
                        if (beat_cnt == CNT_W'(1)) begin
                            state <= WAIT_CMPLT;
                        end
                    end
                end
                WAIT_CMPLT: begin
                    if (proc_cmplt) begin
                        mstr0_cmplt <= 1'b1;
                        rr_ptr      <= (data_source == SRC_W'(NUM_SLV - 1)) ? '0 : data_source + SRC_W'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_multi_arbiter.sv
// tb/tb_ip_multi_arbiter.sv - directed self-checking bench for ip_multi_arbiter
module tb_ip_multi_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0][1:0]   slv_mode;
    logic [3:0]        slv_data_valid;
    logic [3:0][7:0]   slv_proc_valid;
    logic [3:0][31:0]  slv_data;
    logic [3:0]        slv_ready;
    logic              fifo_full;
    logic              proc_cmplt;
    logic [1:0]        slvx_mode;
    logic [7:0]        slvx_proc_val;
    logic              slvx_data_valid;
    logic [31:0]       slvx_data;
    logic [1:0]        data_source;
    logic              mstr0_cmplt;

    int n_cmp = 0;
    int n_err = 0;

    ip_multi_arbiter #(.NUM_SLV(4), .DW(32), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .slv_mode        (slv_mode),
        .slv_data_valid  (slv_data_valid),
        .slv_proc_valid  (slv_proc_valid),
        .slv_data        (slv_data),
        .slv_ready       (slv_ready),
        .fifo_full       (fifo_full),
        .proc_cmplt      (proc_cmplt),
        .slvx_mode       (slvx_mode),
        .slvx_proc_val   (slvx_proc_val),
        .slvx_data_valid (slvx_data_valid),
        .slvx_data       (slvx_data),
        .data_source     (data_source),
        .mstr0_cmplt     (mstr0_cmplt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int s, input int b);
        return 32'hA500_0000 | 32'(s << 8) | 32'(b);
    endfunction

    task automatic clear_inputs();
        slv_data_valid = '0;
        slv_mode       = '0;
        slv_proc_valid = '0;
        slv_data       = '0;
        fifo_full      = 1'b0;
        proc_cmplt     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (slvx_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", slvx_data_valid); end
        n_cmp++; if (data_source !== 2'd0) begin n_err++; $display("FAIL rst_src: got %0d want 0", data_source); end
        n_cmp++; if (slvx_mode !== 2'd0 || slvx_proc_val !== 8'd0) begin n_err++; $display("FAIL rst_latch: got %0d/%0d want 0/0", slvx_mode, slvx_proc_val); end
        n_cmp++; if (slvx_data !== 32'd0 || mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL rst_data: got %h/%b want 0/0", slvx_data, mstr0_cmplt); end
        n_cmp++; if (slv_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", slv_ready); end
    endtask

    task automatic test_single();
        do_reset();
        slv_mode[2] = 2'b01; slv_proc_valid[2] = 8'd3; slv_data[2] = mk(2, 0); slv_data_valid[2] = 1'b1;
        #1;
        n_cmp++; if (slv_ready !== 4'b0000) begin n_err++; $display("FAIL single_idle_ready: got %b want 0000", slv_ready); end
        @(negedge clk);
        n_cmp++; if (data_source !== 2'd2) begin n_err++; $display("FAIL single_src: got %0d want 2", data_source); end
        n_cmp++; if (slvx_mode !== 2'b01 || slvx_proc_val !== 8'd3) begin n_err++; $display("FAIL single_latch: got %0d/%0d want 1/3", slvx_mode, slvx_proc_val); end
        n_cmp++; if (slvx_data_valid !== 1'b0) begin n_err++; $display("FAIL single_grant_valid: got %b want 0", slvx_data_valid); end
        #1;
        n_cmp++; if (slv_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", slv_ready); end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(2, b)) begin n_err++; $display("FAIL single_beat%0d: got %b/%h want 1/%h", b, slvx_data_valid, slvx_data, mk(2, b)); end
            slv_data[2] = mk(2, b + 1);
        end
        slv_data_valid[2] = 1'b0;
        #1;
        n_cmp++; if (slv_ready !== 4'b0000) begin n_err++; $display("FAIL single_wait_ready: got %b want 0000", slv_ready); end
        @(negedge clk);
        n_cmp++; if (slvx_data_valid !== 1'b0 || mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL single_extra: got %b/%b want 0/0", slvx_data_valid, mstr0_cmplt); end
        proc_cmplt = 1'b1;
        @(negedge clk);
        proc_cmplt = 1'b0;
        n_cmp++; if (mstr0_cmplt !== 1'b1) begin n_err++; $display("FAIL single_cmplt: got %b want 1", mstr0_cmplt); end
        @(negedge clk);
        n_cmp++; if (mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL single_cmplt_pulse: got %b want 0", mstr0_cmplt); end
    endtask

    task automatic test_rr_order();
        int exp_src;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            slv_proc_valid[s] = 8'd1; slv_data[s] = mk(s, 0); slv_data_valid[s] = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            exp_src = k % 4;
            @(negedge clk);
            n_cmp++; if (data_source !== 2'(exp_src)) begin n_err++; $display("FAIL rr_src%0d: got %0d want %0d", k, data_source, exp_src); end
            @(negedge clk);
            n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(exp_src, 0)) begin n_err++; $display("FAIL rr_beat%0d: got %b/%h want 1/%h", k, slvx_data_valid, slvx_data, mk(exp_src, 0)); end
            proc_cmplt = 1'b1;
            if (k == 4) slv_data_valid = '0;
            @(negedge clk);
            proc_cmplt = 1'b0;
            n_cmp++; if (mstr0_cmplt !== 1'b1) begin n_err++; $display("FAIL rr_cmplt%0d: got %b want 1", k, mstr0_cmplt); end
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        slv_mode[1] = 2'b10; slv_proc_valid[1] = 8'd4; slv_data[1] = mk(1, 0); slv_data_valid[1] = 1'b1;
        @(negedge clk);
        n_cmp++; if (data_source !== 2'd1 || slvx_mode !== 2'b10) begin n_err++; $display("FAIL ff_grant: got %0d/%0d want 1/2", data_source, slvx_mode); end
        @(negedge clk);
        n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(1, 0)) begin n_err++; $display("FAIL ff_beat0: got %b/%h want 1/%h", slvx_data_valid, slvx_data, mk(1, 0)); end
        slv_data[1] = mk(1, 1);
        fifo_full = 1'b1;
        #1;
        n_cmp++; if (slv_ready !== 4'b0000) begin n_err++; $display("FAIL ff_ready_drop: got %b want 0000", slv_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (slvx_data_valid !== 1'b0 || slv_ready !== 4'b0000) begin n_err++; $display("FAIL ff_stall%0d: got %b/%b want 0/0000", c, slvx_data_valid, slv_ready); end
        end
        fifo_full = 1'b0;
        #1;
        n_cmp++; if (slv_ready !== 4'b0010) begin n_err++; $display("FAIL ff_ready_back: got %b want 0010", slv_ready); end
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(1, b)) begin n_err++; $display("FAIL ff_beat%0d: got %b/%h want 1/%h", b, slvx_data_valid, slvx_data, mk(1, b)); end
            slv_data[1] = mk(1, b + 1);
        end
        slv_data_valid = '0;
        proc_cmplt = 1'b1;
        @(negedge clk);
        proc_cmplt = 1'b0;
        n_cmp++; if (mstr0_cmplt !== 1'b1) begin n_err++; $display("FAIL ff_cmplt: got %b want 1", mstr0_cmplt); end
    endtask

    task automatic test_eligibility();
        do_reset();
        slv_mode[1] = 2'b11; slv_proc_valid[1] = 8'd2; slv_data[1] = mk(1, 0); slv_data_valid[1] = 1'b1;
        slv_mode[3] = 2'b00; slv_proc_valid[3] = 8'd0; slv_data[3] = mk(3, 0); slv_data_valid[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (slv_ready !== 4'b0000 || slvx_data_valid !== 1'b0) begin n_err++; $display("FAIL elig_idle%0d: got %b/%b want 0000/0", c, slv_ready, slvx_data_valid); end
        end
        slv_proc_valid[0] = 8'd1; slv_data[0] = mk(0, 0); slv_data_valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (data_source !== 2'd0) begin n_err++; $display("FAIL elig_src%0d: got %0d want 0", k, data_source); end
            #1;
            n_cmp++; if (slv_ready !== 4'b0001) begin n_err++; $display("FAIL elig_ready%0d: got %b want 0001", k, slv_ready); end
            @(negedge clk);
            n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(0, 0)) begin n_err++; $display("FAIL elig_beat%0d: got %b/%h want 1/%h", k, slvx_data_valid, slvx_data, mk(0, 0)); end
            proc_cmplt = 1'b1;
            if (k == 2) slv_data_valid = '0;
            @(negedge clk);
            proc_cmplt = 1'b0;
            n_cmp++; if (mstr0_cmplt !== 1'b1) begin n_err++; $display("FAIL elig_cmplt%0d: got %b want 1", k, mstr0_cmplt); end
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_inputs();
        slv_proc_valid[0] = 8'd1; slv_data[0] = mk(0, 0); slv_data_valid[0] = 1'b1;
        slv_mode[2] = 2'b01; slv_proc_valid[2] = 8'd5; slv_data[2] = mk(2, 0); slv_data_valid[2] = 1'b1;
        @(negedge clk);
        n_cmp++; if (data_source !== 2'd2) begin n_err++; $display("FAIL rm_src_ptr1: got %0d want 2", data_source); end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(2, b)) begin n_err++; $display("FAIL rm_beat%0d: got %b/%h want 1/%h", b, slvx_data_valid, slvx_data, mk(2, b)); end
            slv_data[2] = mk(2, b + 1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (slvx_data_valid !== 1'b0 || slvx_data !== 32'd0) begin n_err++; $display("FAIL rm_async_data: got %b/%h want 0/0", slvx_data_valid, slvx_data); end
        n_cmp++; if (data_source !== 2'd0 || slvx_mode !== 2'd0 || slvx_proc_val !== 8'd0) begin n_err++; $display("FAIL rm_async_latch: got %0d/%0d/%0d want 0/0/0", data_source, slvx_mode, slvx_proc_val); end
        n_cmp++; if (slv_ready !== 4'b0000 || mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL rm_async_ctl: got %b/%b want 0000/0", slv_ready, mstr0_cmplt); end
        slv_data[2] = mk(2, 0);
        @(negedge clk);
        n_cmp++; if (mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL rm_no_cmplt: got %b want 0", mstr0_cmplt); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (data_source !== 2'd0 || mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL rm_src_ptr0: got %0d/%b want 0/0", data_source, mstr0_cmplt); end
        @(negedge clk);
        n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(0, 0)) begin n_err++; $display("FAIL rm_s0_beat: got %b/%h want 1/%h", slvx_data_valid, slvx_data, mk(0, 0)); end
        proc_cmplt = 1'b1;
        slv_data_valid[0] = 1'b0;
        @(negedge clk);
        proc_cmplt = 1'b0;
        n_cmp++; if (mstr0_cmplt !== 1'b1) begin n_err++; $display("FAIL rm_s0_cmplt: got %b want 1", mstr0_cmplt); end
        @(negedge clk);
        n_cmp++; if (data_source !== 2'd2 || slvx_proc_val !== 8'd5) begin n_err++; $display("FAIL rm_regrant: got %0d/%0d want 2/5", data_source, slvx_proc_val); end
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(2, b)) begin n_err++; $display("FAIL rm_rebeat%0d: got %b/%h want 1/%h", b, slvx_data_valid, slvx_data, mk(2, b)); end
            slv_data[2] = mk(2, b + 1);
        end
        slv_data_valid = '0;
        proc_cmplt = 1'b1;
        @(negedge clk);
        proc_cmplt = 1'b0;
        n_cmp++; if (mstr0_cmplt !== 1'b1) begin n_err++; $display("FAIL rm_s2_cmplt: got %b want 1", mstr0_cmplt); end
    endtask

    task automatic test_cmplt_outside_wait();
        do_reset();
        proc_cmplt = 1'b1;
        @(negedge clk);
        proc_cmplt = 1'b0;
        n_cmp++; if (mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL cx_idle_cmplt: got %b want 0", mstr0_cmplt); end
        slv_proc_valid[3] = 8'd2; slv_data[3] = mk(3, 0); slv_data_valid[3] = 1'b1;
        fifo_full = 1'b1;
        @(negedge clk);
        n_cmp++; if (data_source !== 2'd3) begin n_err++; $display("FAIL cx_src: got %0d want 3", data_source); end
        proc_cmplt = 1'b1;
        @(negedge clk);
        proc_cmplt = 1'b0;
        n_cmp++; if (mstr0_cmplt !== 1'b0 || slvx_data_valid !== 1'b0) begin n_err++; $display("FAIL cx_xfer_cmplt: got %b/%b want 0/0", mstr0_cmplt, slvx_data_valid); end
        fifo_full = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            n_cmp++; if (slvx_data_valid !== 1'b1 || slvx_data !== mk(3, b)) begin n_err++; $display("FAIL cx_beat%0d: got %b/%h want 1/%h", b, slvx_data_valid, slvx_data, mk(3, b)); end
            slv_data[3] = mk(3, b + 1);
        end
        slv_data_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL cx_wait%0d: got %b want 0", c, mstr0_cmplt); end
        end
        proc_cmplt = 1'b1;
        @(negedge clk);
        proc_cmplt = 1'b0;
        n_cmp++; if (mstr0_cmplt !== 1'b1) begin n_err++; $display("FAIL cx_cmplt: got %b want 1", mstr0_cmplt); end
        @(negedge clk);
        n_cmp++; if (mstr0_cmplt !== 1'b0) begin n_err++; $display("FAIL cx_cmplt_pulse: got %b want 0", mstr0_cmplt); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_rr_order();
        test_fifo_full();
        test_eligibility();
        test_reset_mid_burst();
        test_cmplt_outside_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
